// File: rtl/uart_tx_arbiter_if.sv
// Bus between the UART TX arbiter, its byte sources and the transmitter.
// The master modport is the arbiter side. The slave modport is the
// environment side: the requesters, the baud generator and the transmitter.
interface uart_tx_arbiter_if #(
    parameter int NB_DATA = 8,
    parameter int NB_REQ  = 4
);
    localparam int NB_ID = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

    logic                      i_tick;
    logic [NB_REQ-1:0]         i_req;
    logic [NB_REQ*NB_DATA-1:0] i_data;
    logic                      i_txdone;
    logic [NB_REQ-1:0]         o_ack;
    logic                      o_start_tx;
    logic [NB_DATA-1:0]        o_tx_data;
    logic [NB_ID-1:0]          o_grant_id;
    logic                      o_busy;
    logic                      o_timeout;

    modport master (
        input  i_tick, i_req, i_data, i_txdone,
        output o_ack, o_start_tx, o_tx_data, o_grant_id, o_busy, o_timeout
    );

    modport slave (
        output i_tick, i_req, i_data, i_txdone,
        input  o_ack, o_start_tx, o_tx_data, o_grant_id, o_busy, o_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART transmitter among NB_REQ byte
// sources. It grants one requester, launches that byte and waits for the
// done pulse. It then holds off for NB_GAP baud ticks before granting again.
// Optional feature: define UART_TX_ARBITER_WDOG_EN to add a WAIT watchdog.
// The watchdog gives up after NB_WDOG cycles and pulses o_timeout.
module uart_tx_arbiter #(
    parameter int NB_DATA = 8,
    parameter int NB_REQ  = 4,
    parameter int NB_GAP  = 16,
    parameter int NB_WDOG = 4096
) (
    input  logic               clk,
    input  logic               i_rst,
    uart_tx_arbiter_if.master  bus
);
    localparam int NB_ID    = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int NB_GCNT  = (NB_GAP > 1) ? $clog2(NB_GAP) : 1;
    localparam int GAP_LAST = (NB_GAP > 0) ? NB_GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // Reject parameter values the selection and counter logic cannot handle.
    if (NB_REQ < 2 || NB_REQ > 8) begin : g_bad_nb_req
        $error("uart_tx_arbiter: NB_REQ must be in 2..8");
    end
    if (NB_WDOG < 1) begin : g_bad_nb_wdog
        $error("uart_tx_arbiter: NB_WDOG must be at least 1");
    end

    state_t               state_q, state_nxt;
    logic [NB_ID-1:0]     rr_q, rr_nxt;
    logic [NB_GCNT-1:0]   gap_q, gap_nxt;
    logic [NB_REQ-1:0]    ack_q, ack_nxt;
    logic                 start_q, start_nxt;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_nxt;
    logic [NB_ID-1:0]     grant_q, grant_nxt;
    logic                 busy_q, busy_nxt;

    logic                 found;
    logic [NB_ID-1:0]     pick;
    logic [NB_DATA-1:0]   pick_data;

`ifdef UART_TX_ARBITER_WDOG_EN
    localparam int NB_WCNT   = (NB_WDOG > 1) ? $clog2(NB_WDOG) : 1;
    localparam int WDOG_LAST = NB_WDOG - 1;

    logic [NB_WCNT-1:0]   wdog_q, wdog_nxt;
    logic                 timeout_q, timeout_nxt;
`endif

    // Search for the first active request, starting just after the last grant.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NB_REQ; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NB_REQ;
            if (!found && bus.i_req[idx]) begin
                found = 1'b1;
                pick  = NB_ID'(idx);
            end
        end
        pick_data = bus.i_data[int'(pick)*NB_DATA +: NB_DATA];
    end

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_nxt   = state_q;
        rr_nxt      = rr_q;
        gap_nxt     = gap_q;
        ack_nxt     = '0;
        start_nxt   = 1'b0;
        tx_data_nxt = tx_data_q;
        grant_nxt   = grant_q;
`ifdef UART_TX_ARBITER_WDOG_EN
        wdog_nxt    = wdog_q;
        timeout_nxt = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_nxt       = S_LAUNCH;
                    ack_nxt[pick]   = 1'b1;
                    start_nxt       = 1'b1;
                    tx_data_nxt     = pick_data;
                    grant_nxt       = pick;
                    rr_nxt          = pick;
                end
            end
            S_LAUNCH: begin
                // A done pulse here is dropped: the transmitter cannot finish this fast.
                state_nxt = S_WAIT;
`ifdef UART_TX_ARBITER_WDOG_EN
                wdog_nxt  = '0;
`endif
            end
            S_WAIT: begin
                if (bus.i_txdone) begin
                    gap_nxt   = '0;
                    state_nxt = (NB_GAP > 0) ? S_GAP : S_IDLE;
                end
`ifdef UART_TX_ARBITER_WDOG_EN
                else if (wdog_q == NB_WCNT'(WDOG_LAST)) begin
                    // Abandon the frame. rr_q keeps this requester, so the next search moves past it.
                    timeout_nxt = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    wdog_nxt = wdog_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (bus.i_tick) begin
                    if (gap_q == NB_GCNT'(GAP_LAST)) begin
                        state_nxt = S_IDLE;
                    end else begin
                        gap_nxt = gap_q + 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_rst) begin
            state_q   <= S_IDLE;
            rr_q      <= NB_ID'(NB_REQ - 1);
            gap_q     <= '0;
            ack_q     <= '0;
            start_q   <= 1'b0;
            tx_data_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            rr_q      <= rr_nxt;
            gap_q     <= gap_nxt;
            ack_q     <= ack_nxt;
            start_q   <= start_nxt;
            tx_data_q <= tx_data_nxt;
            grant_q   <= grant_nxt;
            busy_q    <= busy_nxt;
        end
    end

`ifdef UART_TX_ARBITER_WDOG_EN
    // Watchdog counter and timeout pulse register.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign bus.o_timeout = timeout_q;
`else
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_ack      = ack_q;
    assign bus.o_start_tx = start_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_grant_id = grant_q;
    assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. A table of per-cycle vectors drives
// and checks a DUT with NB_GAP=2. Hand-written sequences cover fairness, the
// zero-gap build, and watchdog behaviour with and without UART_TX_ARBITER_WDOG_EN.
module tb_uart_tx_arbiter;
    localparam logic [31:0] D_STD = 32'h1312_1110;
    localparam logic [31:0] D_A5  = 32'h13A5_1110;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic        txdone;
        logic        tick;
        logic [3:0]  ack;
        logic        start;
        logic [7:0]  tx_data;
        logic [1:0]  gid;
        logic        busy;
    } vec_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_checks;
    int   n_pass;
    vec_t vq[$];

    uart_tx_arbiter_if #(.NB_DATA(8), .NB_REQ(4)) bus_a ();
    uart_tx_arbiter_if #(.NB_DATA(8), .NB_REQ(4)) bus_b ();

    uart_tx_arbiter #(.NB_DATA(8), .NB_REQ(4), .NB_GAP(2), .NB_WDOG(32)) dut_a (
        .clk   (clk),
        .i_rst (rst_a),
        .bus   (bus_a)
    );

    uart_tx_arbiter #(.NB_DATA(8), .NB_REQ(4), .NB_GAP(0), .NB_WDOG(32)) dut_b (
        .clk   (clk),
        .i_rst (rst_b),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic add_vec(input logic rst, input logic [3:0] req, input logic [31:0] data,
                           input logic txdone, input logic tick, input logic [3:0] ack,
                           input logic start, input logic [7:0] tx_data, input logic [1:0] gid,
                           input logic busy);
        vec_t v;
        v.rst = rst; v.req = req; v.data = data; v.txdone = txdone; v.tick = tick;
        v.ack = ack; v.start = start; v.tx_data = tx_data; v.gid = gid; v.busy = busy;
        vq.push_back(v);
    endtask

    task automatic reset_a();
        @(negedge clk);
        rst_a = 1'b1;
        bus_a.i_req = '0; bus_a.i_txdone = 1'b0; bus_a.i_tick = 1'b0; bus_a.i_data = D_STD;
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    // All four requesters held high: grants must rotate, with two ticks of gap before each regrant.
    task automatic run_fairness();
        int order[5] = '{0, 1, 2, 3, 0};
        int n_start  = 0;
        int done_at  = -1;
        int n_ticks  = 0;
        bit counting = 1'b0;
        reset_a();
        bus_a.i_req = 4'hF;
        for (int c = 0; c < 300 && n_start < 5; c++) begin
            bus_a.i_tick   = (c % 4 == 0);
            bus_a.i_txdone = (c == done_at);
            @(posedge clk);
            #1;
            if (counting && bus_a.i_tick) n_ticks++;
            if (bus_a.i_txdone) begin
                counting = 1'b1;
                n_ticks  = 0;
            end
            if (bus_a.o_start_tx) begin
                check($sformatf("fair_gid%0d", n_start), 32'(bus_a.o_grant_id), 32'(order[n_start]));
                check($sformatf("fair_ack%0d", n_start), 32'(bus_a.o_ack), 32'(1) << order[n_start]);
                check($sformatf("fair_data%0d", n_start), 32'(bus_a.o_tx_data), 32'h10 + 32'(order[n_start]));
                if (n_start > 0) check($sformatf("fair_ticks%0d", n_start), 32'(n_ticks), 32'd2);
                counting = 1'b0;
                n_start++;
                done_at = c + 5;
            end
            @(negedge clk);
        end
        check("fair_nstarts", 32'(n_start), 32'd5);
        bus_a.i_tick = 1'b0; bus_a.i_txdone = 1'b0; bus_a.i_req = '0;
    endtask

    // NB_GAP=0: done in WAIT returns to IDLE at once, and the held request relaunches one cycle later.
    task automatic run_no_gap();
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        bus_b.i_req = 4'b0010;
        @(posedge clk); #1;
        check("ng_start1", 32'(bus_b.o_start_tx), 32'd1);
        check("ng_ack1", 32'(bus_b.o_ack), 32'h2);
        check("ng_gid1", 32'(bus_b.o_grant_id), 32'd1);
        check("ng_data1", 32'(bus_b.o_tx_data), 32'h11);
        @(posedge clk); #1;
        check("ng_wait_busy", 32'(bus_b.o_busy), 32'd1);
        check("ng_wait_start", 32'(bus_b.o_start_tx), 32'd0);
        @(negedge clk);
        bus_b.i_txdone = 1'b1;
        @(posedge clk); #1;
        check("ng_idle_busy", 32'(bus_b.o_busy), 32'd0);
        check("ng_idle_start", 32'(bus_b.o_start_tx), 32'd0);
        @(negedge clk);
        bus_b.i_txdone = 1'b0;
        @(posedge clk); #1;
        check("ng_start2", 32'(bus_b.o_start_tx), 32'd1);
        check("ng_ack2", 32'(bus_b.o_ack), 32'h2);
        check("ng_gid2", 32'(bus_b.o_grant_id), 32'd1);
    endtask

    // No done pulse ever arrives: watchdog expiry with the macro, indefinite WAIT without it.
    task automatic run_wdog();
        reset_a();
        bus_a.i_req = 4'b0001;
        @(posedge clk); #1;
        check("wd_start", 32'(bus_a.o_start_tx), 32'd1);
        check("wd_gid", 32'(bus_a.o_grant_id), 32'd0);
        @(negedge clk);
        bus_a.i_req = '0;
`ifdef UART_TX_ARBITER_WDOG_EN
        // k counts edges after launch; WAIT is entered at k=1, so expiry is due at k=33.
        for (int k = 1; k <= 33; k++) begin
            @(posedge clk); #1;
            check($sformatf("wd_timeout_k%0d", k), 32'(bus_a.o_timeout), (k == 33) ? 32'd1 : 32'd0);
            check($sformatf("wd_busy_k%0d", k), 32'(bus_a.o_busy), (k == 33) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        bus_a.i_req = 4'b0011;
        @(posedge clk); #1;
        check("wd_next_start", 32'(bus_a.o_start_tx), 32'd1);
        check("wd_next_gid", 32'(bus_a.o_grant_id), 32'd1);
        check("wd_next_ack", 32'(bus_a.o_ack), 32'h2);
        check("wd_next_timeout", 32'(bus_a.o_timeout), 32'd0);
`else
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            check($sformatf("wd_timeout_k%0d", k), 32'(bus_a.o_timeout), 32'd0);
            check($sformatf("wd_busy_k%0d", k), 32'(bus_a.o_busy), 32'd1);
        end
`endif
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.i_req = '0; bus_a.i_data = D_STD; bus_a.i_txdone = 1'b0; bus_a.i_tick = 1'b0;
        bus_b.i_req = '0; bus_b.i_data = D_STD; bus_b.i_txdone = 1'b0; bus_b.i_tick = 1'b0;

        //       rst   req      data   done  tick   ack      st    txd    gid    busy
        add_vec(1'b1, 4'b0000, D_STD, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0); // reset
        add_vec(1'b0, 4'b0100, D_A5,  1'b0, 1'b0, 4'b0100, 1'b1, 8'hA5, 2'd2, 1'b1); // grant lane 2
        add_vec(1'b0, 4'b0000, D_STD, 1'b0, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1); // WAIT
        add_vec(1'b0, 4'b0000, D_STD, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1); // done -> GAP
        add_vec(1'b0, 4'b0001, D_STD, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1); // done, req in GAP
        add_vec(1'b0, 4'b0001, D_STD, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1); // tick 1
        add_vec(1'b0, 4'b0001, D_STD, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0); // tick 2 -> IDLE
        add_vec(1'b0, 4'b0000, D_STD, 1'b1, 1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0); // done in IDLE
        add_vec(1'b0, 4'b0001, D_STD, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1); // wrap to lane 0
        add_vec(1'b0, 4'b0000, D_STD, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b1); // WAIT
        add_vec(1'b0, 4'b0000, D_STD, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b1); // tick in WAIT
        add_vec(1'b0, 4'b0000, D_STD, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b1); // done -> GAP
        add_vec(1'b0, 4'b0000, D_STD, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b1); // tick 1
        add_vec(1'b0, 4'b1000, D_STD, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b0); // tick 2 -> IDLE
        add_vec(1'b0, 4'b1000, D_STD, 1'b0, 1'b0, 4'b1000, 1'b1, 8'h13, 2'd3, 1'b1); // grant lane 3
        add_vec(1'b0, 4'b0000, D_STD, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h13, 2'd3, 1'b1); // WAIT
        add_vec(1'b1, 4'b1001, D_STD, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0); // reset in WAIT
        add_vec(1'b0, 4'b1001, D_STD, 1'b0, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1); // lane 0 first
        add_vec(1'b0, 4'b1000, D_STD, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h10, 2'd0, 1'b1); // WAIT

        foreach (vq[i]) begin
            @(negedge clk);
            rst_a          = vq[i].rst;
            bus_a.i_req    = vq[i].req;
            bus_a.i_data   = vq[i].data;
            bus_a.i_txdone = vq[i].txdone;
            bus_a.i_tick   = vq[i].tick;
            @(posedge clk); #1;
            check($sformatf("v%0d_ack", i), 32'(bus_a.o_ack), 32'(vq[i].ack));
            check($sformatf("v%0d_start", i), 32'(bus_a.o_start_tx), 32'(vq[i].start));
            check($sformatf("v%0d_txdata", i), 32'(bus_a.o_tx_data), 32'(vq[i].tx_data));
            check($sformatf("v%0d_gid", i), 32'(bus_a.o_grant_id), 32'(vq[i].gid));
            check($sformatf("v%0d_busy", i), 32'(bus_a.o_busy), 32'(vq[i].busy));
            check($sformatf("v%0d_timeout", i), 32'(bus_a.o_timeout), 32'd0);
        end

        run_fairness();
        run_no_gap();
        run_wdog();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter among NB_REQ byte sources. Each requester offers one byte via a req/ack handshake. The block grants one requester, launches the byte with a start pulse and waits for the transmitter's done pulse. It then enforces an inter-frame idle gap, measured in baud ticks, before granting again. It sits between the application sources and the UART TX datapath, and drives that datapath's start/data inputs.

Parameters:
NB_DATA, 8, byte width per requester and to the transmitter
NB_REQ, 4, number of requesters (2..8)
NB_GAP, 16, idle baud ticks between frames (0 = no gap)
NB_WDOG, 4096, clock cycles allowed in WAIT before timeout (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_tick  input  1  baud-rate tick strobe, one clk wide
i_req  input  NB_REQ  per-requester byte-valid level
i_data  input  NB_REQ*NB_DATA  requester k byte at bits [k*NB_DATA +: NB_DATA]
o_ack  output  NB_REQ  one-hot, one-cycle pulse: byte of that requester taken
o_start_tx  output  1  one-cycle launch pulse to transmitter
o_tx_data  output  NB_DATA  byte to transmitter, held stable from launch until done
i_txdone  input  1  transmitter frame-complete pulse
o_grant_id  output  clogb2(NB_REQ)  index of the current or last granted requester
o_busy  output  1  high in any state except IDLE
o_timeout  output  1  one-cycle pulse on watchdog expiry (constant 0 without the feature)

Behaviour:
- Reset is synchronous and active-high, with one clock: clk, i_rst. Registered reset values:
  - state=IDLE
  - o_ack=0, o_start_tx=0, o_tx_data=0, o_grant_id=0, o_busy=0, o_timeout=0
  - gap counter=0
  - rr pointer=NB_REQ-1, so requester 0 wins first
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT, GAP.
- IDLE:
  - If any i_req bit is set at edge N, choose the first set bit searching from rr_ptr+1 upward, with modulo NB_REQ wrap.
  - At N+1: state=LAUNCH.
  - o_tx_data latches that requester's byte.
  - o_ack[k]=1 and o_start_tx=1 for exactly that cycle.
  - o_grant_id=k, rr_ptr=k.
- LAUNCH: lasts one cycle and always moves to WAIT. i_txdone is ignored in LAUNCH.
- WAIT:
  - On i_txdone=1: go to GAP if NB_GAP>0, else IDLE.
  - i_tick is ignored.
- GAP:
  - Counter counts i_tick pulses; it is cleared on entry.
  - When it reaches NB_GAP-1 on a tick, go to IDLE.
  - i_req is ignored; no grant is possible during GAP.
- Earliest regrant: the first cycle in IDLE after GAP exit. Requests are evaluated fresh there.
- Requester rules:
  - Must hold i_req and i_data stable until its ack.
  - Must deassert or present the next byte in the cycle after the ack.
  - A req dropped before grant is simply not selected; there is no error.
- Fairness: with all requesters continuously asserting, grants cycle 0,1,2,...,NB_REQ-1,0. No requester waits more than NB_REQ-1 frames.
- o_tx_data is held from LAUNCH until the next grant; it is never modified in WAIT or GAP.
- i_txdone outside WAIT is ignored. A done pulse coincident with the LAUNCH cycle is lost, so the transmitter must not raise done within one cycle of start.
- Reset asserted mid-operation (any state) returns to the reset values on the next edge.
  - No ack or start is issued in that cycle.
  - An in-flight frame on the transmitter is abandoned.

Optional Feature:
Macro UART_TX_ARBITER_WDOG_EN.
- Defined:
  - A cycle counter runs in WAIT; it is cleared on entry to WAIT.
  - If NB_WDOG cycles elapse without i_txdone, o_timeout pulses for one cycle and the FSM goes to IDLE, skipping GAP.
  - rr_ptr keeps the timed-out requester, so the next search starts after it.
- Not defined:
  - No counter logic; o_timeout is tied 0.
  - WAIT persists indefinitely until i_txdone.

Test Plan:
1. Reset, then i_req=4'b0100 with byte 0xA5 on lane 2. Required:
   - o_ack=4'b0100 and o_start_tx=1 one cycle later, with o_tx_data=0xA5 and o_grant_id=2.
   - o_busy=1 until the gap ends.
2. All four requesters held high with bytes 0x10..0x13; i_txdone pulsed 5 cycles after each start; NB_GAP=2 with a tick every 4 clocks. Required:
   - Grant order 0,1,2,3,0.
   - Exactly 2 ticks between each done and the next start.
3. NB_GAP=0, requester 1 held high. Required: i_txdone in WAIT produces IDLE on the next edge, with the next o_start_tx one cycle later.
4. Requester 3 granted. Assert i_rst for one cycle in WAIT. Required:
   - All outputs are 0 next cycle.
   - With i_req=4'b1001 after reset, requester 0 is granted first.
5. i_txdone pulsed during GAP and during IDLE. Required: no state change and no spurious start.
6. UART_TX_ARBITER_WDOG_EN defined, NB_WDOG=32, no i_txdone. Required:
   - o_timeout pulses exactly 32 cycles after WAIT entry.
   - Next grant goes to the next requester in rotation.
   - Without the macro, o_timeout stays 0 and o_busy stays 1.
